// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//   Wishbone classic single-transfer initiator. One command is accepted on a
//   valid/ready port, and the module then drives cyc/stb until the slave acks
//   or a timeout expires. The result (read data and an error flag) comes back
//   on a valid/ready response port. Only one transfer is outstanding at a time.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_we/adr/dat/sel         command fields (write enable, address, data,
//                              byte selects)
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_err         read data (0 for writes and timeouts) and
//                              timeout flag
//   wbm_*_o / wbm_*_i          Wishbone classic master interface
//
// Parameters
//   ADDR_W, DATA_W             bus widths (SEL_W = DATA_W/8)
//   TIMEOUT                    maximum cycles stb is held without ack;
//                              0 = wait forever
// ---------------------------------------------------------------------------
module wb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  // command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_adr,
  input  logic [DATA_W-1:0]   cmd_dat,
  input  logic [DATA_W/8-1:0] cmd_sel,
  // response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  // Wishbone master
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  input  logic                wbm_ack_i,
  input  logic [DATA_W-1:0]   wbm_dat_i
);

  localparam int SEL_W = DATA_W / 8;

  // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
  // TIMEOUT=0 (wait forever) build still has a legal vector.
  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic              cyc_q,       cyc_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] adr_q,       adr_d;
  logic [DATA_W-1:0] dat_q,       dat_d;
  logic [SEL_W-1:0]  sel_q,       sel_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          state_d = ST_BUS;
        end
      end

      ST_BUS: begin
        // Ack is tested first so an ack on the final allowed cycle still
        // counts as a successful transfer.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_rdata_d = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          cyc_d       = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others, independent of statement order.
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_master
//   Directed and random transfers against wb_cmd_master (TIMEOUT=16). The
//   expected response of every transfer is pushed to a queue when the command
//   is issued and popped when the response handshake happens.
// ---------------------------------------------------------------------------
module tb_wb_cmd_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];

  always #5 clk = ~clk;

  wb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus-protocol monitor on the falling edge: stb tracks cyc, and the address
  // does not move while stb stays high.
  logic        prev_stb = 1'b0;
  logic [31:0] prev_adr = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("stb_eq_cyc", {63'd0, wbm_stb_o}, {63'd0, wbm_cyc_o});
      if (prev_stb && wbm_stb_o)
        check("adr_stable", {32'd0, wbm_adr_o}, {32'd0, prev_adr});
    end
    prev_stb = rst_n && wbm_stb_o;
    prev_adr = wbm_adr_o;
  end

  // One complete transfer. ack_at is the stb cycle (1-based) on which the
  // slave acks; 0 or anything beyond TO means the slave never acks.
  // rsp_stall is the number of cycles rsp_ready is held low once rsp_valid
  // is up; during that time a bogus command is offered and must be ignored.
  task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_at, input logic [31:0] sdata,
                         input int rsp_stall, output int stb_cycles);
    rsp_t exp;
    rsp_t got;
    int   guard;
    exp.err   = (ack_at == 0) || (ack_at > TO);
    exp.rdata = (exp.err || we) ? 32'd0 : sdata;
    sb.push_back(exp);

    check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    tick();
    // The command is now latched; offer junk that must be ignored.
    cmd_we  = ~we;
    cmd_adr = $urandom;
    cmd_dat = $urandom;
    cmd_sel = 4'($urandom);
    check("wbm_we",  {63'd0, wbm_we_o}, {63'd0, we});
    check("wbm_adr", {32'd0, wbm_adr_o}, {32'd0, adr});
    check("wbm_dat", {32'd0, wbm_dat_o}, {32'd0, dat});
    check("wbm_sel", {60'd0, wbm_sel_o}, {60'd0, sel});

    stb_cycles = 0;
    guard = 0;
    while (wbm_stb_o && guard < 100) begin
      stb_cycles++;
      guard++;
      if (stb_cycles == ack_at) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = sdata;
      end else begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = $urandom;
      end
      tick();
    end
    wbm_ack_i = 1'b0;
    wbm_dat_i = $urandom;
    check("stb_dropped", {63'd0, wbm_stb_o}, 64'd0);
    check("rsp_valid_after_bus", {63'd0, rsp_valid}, 64'd1);

    for (int i = 0; i < rsp_stall; i++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      tick();
      check("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("stall_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      check("stall_rdata", {32'd0, rsp_rdata}, {32'd0, exp.rdata});
      check("stall_err", {63'd0, rsp_err}, {63'd0, exp.err});
      check("stall_no_cyc", {63'd0, wbm_cyc_o}, 64'd0);
    end

    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    got = sb.pop_front();
    check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, got.rdata});
    check("rsp_err", {63'd0, rsp_err}, {63'd0, got.err});
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_cleared", {63'd0, rsp_valid}, 64'd0);
    check("cmd_ready_after_hs", {63'd0, cmd_ready}, 64'd1);
  endtask

  initial begin
    int n;
    logic        rwe;
    logic [31:0] rdat;

    // Reset state
    rst_n = 1'b0;
    #1;
    check("rst_cyc", {63'd0, wbm_cyc_o}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_adr", {32'd0, wbm_adr_o}, 64'd0);
    check("rst_we", {63'd0, wbm_we_o}, 64'd0);
    check("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("rst_err", {63'd0, rsp_err}, 64'd0);

    // 1: write, ack on 3rd stb cycle
    do_xfer(1'b1, 32'h3000_0004, 32'h0000_0055, 4'hF, 3, 32'hDEAD_BEEF, 0, n);
    check("t1_stb_cycles", 64'(n), 64'd3);

    // 2: read, immediate ack
    do_xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 32'h0000_00A5, 0, n);
    check("t2_stb_cycles", 64'(n), 64'd1);

    // 3: read timeout, then ack on the last allowed cycle
    do_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 32'h1234_5678, 0, n);
    check("t3_timeout_cycles", 64'(n), 64'(TO));
    do_xfer(1'b0, 32'h3000_000C, 32'h0, 4'h3, TO, 32'h8765_4321, 0, n);
    check("t3_ack_last_cycles", 64'(n), 64'(TO));

    // 4: response back-pressure for 5 cycles
    do_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 2, 32'h0000_5A5A, 5, n);
    check("t4_stb_cycles", 64'(n), 64'd2);

    // 5: reset on the 2nd stb cycle
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3000_0014;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("t5_stb_before_rst", {63'd0, wbm_stb_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_cyc_async", {63'd0, wbm_cyc_o}, 64'd0);
    check("t5_stb_async", {63'd0, wbm_stb_o}, 64'd0);
    check("t5_rsp_valid_async", {63'd0, rsp_valid}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hFFFF_FFFF;
    tick();
    wbm_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_stray_rsp", {63'd0, rsp_valid}, 64'd0);
      check("t5_stray_cyc", {63'd0, wbm_cyc_o}, 64'd0);
      check("t5_stray_ready", {63'd0, cmd_ready}, 64'd1);
      tick();
    end

    // 6: random back-to-back traffic against a random-latency slave
    for (int i = 0; i < 200; i++) begin
      rwe  = 1'($urandom);
      rdat = $urandom;
      do_xfer(rwe, $urandom, $urandom, 4'($urandom), int'($urandom_range(1, TO + 2)),
              rdat, int'($urandom_range(0, 2)), n);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
